// File: rtl/muu_arb_pkg.sv
// Shared types and default widths for the response arbiter.
package muu_arb_pkg;

    localparam int unsigned DefDataWidth = 608;
    localparam int unsigned DefUserWidth = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StPass = 1'b1
    } arb_state_e;

endpackage

// File: rtl/muu_rr_picker.sv
// Combinational rotate-priority picker: first valid index strictly after last_grant_i, wrapping.
module muu_rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   index_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        any_o   = 1'b0;
        index_o = '0;
        cand    = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last_grant_i) + off) % NUM_REQ);
            if (!any_o && valid_i[cand]) begin
                any_o   = 1'b1;
                index_o = cand;
            end
        end
    end

endmodule

// File: rtl/muu_resp_arbiter.sv
// Packet-level round-robin merge of NUM_REQ response streams into one registered output.
// Define MUU_RESP_ARB_PKT_LIMIT_EN to cut packets at MAX_WORDS_IN_PACKET words.
module muu_resp_arbiter
    import muu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ             = 4,
    parameter int unsigned DATA_WIDTH          = DefDataWidth,
    parameter int unsigned USER_WIDTH          = DefUserWidth,
    parameter int unsigned MAX_WORDS_IN_PACKET = 160
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*USER_WIDTH-1:0] req_user,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [USER_WIDTH-1:0]         out_user,
    output logic                          out_valid,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
    output logic                          busy,
    output logic [15:0]                   forced_last_cnt
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    arb_state_e              state_q, state_d;
    logic [IdxW-1:0]         grant_idx_q, grant_idx_d;
    logic [IdxW-1:0]         last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [USER_WIDTH-1:0]   out_user_q, out_user_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;

    logic                    pick_any;
    logic [IdxW-1:0]         pick_idx;
    logic                    out_free;
    logic                    accept;
    logic                    word_last;

`ifdef MUU_RESP_ARB_PKT_LIMIT_EN
    localparam int unsigned CntW = $clog2(MAX_WORDS_IN_PACKET + 1);

    logic [CntW-1:0]         word_cnt_q, word_cnt_d;
    logic [15:0]             forced_cnt_q, forced_cnt_d;
    logic                    at_limit;
`endif

    muu_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IdxW)
    ) u_picker (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .any_o        (pick_any),
        .index_o      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        out_data_d   = out_data_q;
        out_user_d   = out_user_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        req_ready    = '0;
        out_free     = !out_valid_q || out_ready;
        accept       = 1'b0;
        word_last    = 1'b0;
`ifdef MUU_RESP_ARB_PKT_LIMIT_EN
        word_cnt_d   = word_cnt_q;
        forced_cnt_d = forced_cnt_q;
        at_limit     = 1'b0;
`endif

        // Drain happens independently of the FSM so IDLE can re-arbitrate in the same cycle.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    state_d     = StPass;
`ifdef MUU_RESP_ARB_PKT_LIMIT_EN
                    word_cnt_d  = '0;
`endif
                end
            end
            StPass: begin
                req_ready[grant_idx_q] = out_free;
                accept    = req_valid[grant_idx_q] && out_free;
                word_last = req_last[grant_idx_q];
`ifdef MUU_RESP_ARB_PKT_LIMIT_EN
                at_limit  = (word_cnt_q == CntW'(MAX_WORDS_IN_PACKET - 1));
                if (at_limit) begin
                    word_last = 1'b1;
                end
`endif
                if (accept) begin
                    out_data_d  = req_data[32'(grant_idx_q)*DATA_WIDTH +: DATA_WIDTH];
                    out_user_d  = req_user[32'(grant_idx_q)*USER_WIDTH +: USER_WIDTH];
                    out_valid_d = 1'b1;
                    out_last_d  = word_last;
`ifdef MUU_RESP_ARB_PKT_LIMIT_EN
                    word_cnt_d  = word_cnt_q + CntW'(1);
                    if (at_limit && !req_last[grant_idx_q] && forced_cnt_q != 16'hFFFF) begin
                        forced_cnt_d = forced_cnt_q + 16'd1;
                    end
`endif
                    if (word_last) begin
                        state_d      = StIdle;
                        last_grant_d = grant_idx_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            grant_idx_q  <= '0;
            last_grant_q <= IdxW'(NUM_REQ - 1);
            out_data_q   <= '0;
            out_user_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            out_data_q   <= out_data_d;
            out_user_q   <= out_user_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
        end
    end

`ifdef MUU_RESP_ARB_PKT_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q   <= '0;
            forced_cnt_q <= '0;
        end else begin
            word_cnt_q   <= word_cnt_d;
            forced_cnt_q <= forced_cnt_d;
        end
    end

    assign forced_last_cnt = forced_cnt_q;
`else
    assign forced_last_cnt = 16'h0000;
`endif

    assign out_data  = out_data_q;
    assign out_user  = out_user_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == StPass);

endmodule
